// File: rtl/tx_pkg.sv
// Shared types and defaults for the 10G transmit control path.
// State codes, frame length limits and the saturating byte adder live here.
package tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_PAD      = 3'd3,
    ST_FCS      = 3'd4,
    ST_IFG      = 3'd5
  } tx_state_e;

  localparam int unsigned IFG_CYCLES_DEF = 2;
  localparam int unsigned MIN_LEN_DEF    = 60;
  localparam int unsigned MAX_LEN_DEF    = 1518;
  localparam int unsigned JUMBO_LEN_DEF  = 9018;
  localparam int unsigned FCS_BYTES      = 4;
  localparam int unsigned BC_W           = 14;

  localparam logic [BC_W-1:0] BC_MAX = '1;

  function automatic logic [BC_W-1:0] sat_add(
    logic [BC_W-1:0] a,
    logic [3:0]      b
  );
    logic [BC_W:0] s;
    s = {1'b0, a} + {{(BC_W-3){1'b0}}, b};
    return s[BC_W] ? BC_MAX : s[BC_W-1:0];
  endfunction

endpackage

// File: rtl/tx_state_machine_if.sv
// Client-side control and status bundle of the transmit state machine.
// The client drives master; the state machine is the slave.
interface tx_state_machine_if;
  import tx_pkg::*;

  logic            tx_enable;
  logic            inband_fcs;
  logic            jumbo_enable;
  logic            tx_start;
  logic            tx_data_valid;
  logic            tx_last;
  logic [2:0]      tx_last_bytes;

  logic            tx_ack;
  logic            start_preamble;
  logic            start_data;
  logic            start_pad;
  logic            start_fcs;
  logic            crc_init;
  logic            crc_enable;
  logic            transmitting;
  logic            tx_end;
  logic            tx_error;
  logic            good_frame_sent;
  logic            bad_frame_sent;
  logic [BC_W-1:0] byte_count;

  modport master (
    output tx_enable, inband_fcs, jumbo_enable,
    output tx_start, tx_data_valid, tx_last,
    output tx_last_bytes,
    input  tx_ack, start_preamble, start_data,
    input  start_pad, start_fcs, crc_init,
    input  crc_enable, transmitting, tx_end,
    input  tx_error, good_frame_sent,
    input  bad_frame_sent, byte_count
  );

  modport slave (
    input  tx_enable, inband_fcs, jumbo_enable,
    input  tx_start, tx_data_valid, tx_last,
    input  tx_last_bytes,
    output tx_ack, start_preamble, start_data,
    output start_pad, start_fcs, crc_init,
    output crc_enable, transmitting, tx_end,
    output tx_error, good_frame_sent,
    output bad_frame_sent, byte_count
  );

endinterface

// File: rtl/tx_state_machine_ifg_counter.sv
// Inter-frame gap down-counter: loaded on IFG entry,
// zero_o tells the state machine the gap has elapsed.
module ifg_counter
  import tx_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = IFG_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned LOADV =
    (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= 16'(LOADV);
    end else if (dec_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tx_state_machine.sv
// Frame sequencer for the transmit path: preamble, data,
// pad, FCS and inter-frame gap, with length policing.
module tx_state_machine
  import tx_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = IFG_CYCLES_DEF,
  parameter int unsigned MIN_LEN    = MIN_LEN_DEF,
  parameter int unsigned MAX_LEN    = MAX_LEN_DEF,
  parameter int unsigned JUMBO_LEN  = JUMBO_LEN_DEF
) (
  input logic               txclk,
  input logic               reset,
  tx_state_machine_if.slave bus
);

  localparam logic [BC_W-1:0] MIN_W   = BC_W'(MIN_LEN);
  localparam logic [BC_W-1:0] MAX_W   = BC_W'(MAX_LEN);
  localparam logic [BC_W-1:0] JUMBO_W = BC_W'(JUMBO_LEN);
  localparam logic [BC_W-1:0] FCS_W   = BC_W'(FCS_BYTES);

  tx_state_e       state_q, state_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [BC_W-1:0] bc_new, bc_pad;
  logic [BC_W-1:0] lim, act_max;
  logic [3:0]      add_b;
  logic            good, bad;
  logic            ifg_zero, ifg_load;
  logic            run;

  always_comb begin
    add_b = 4'd0;
    if (bus.tx_data_valid) begin
      add_b = bus.tx_last
            ? {1'b0, bus.tx_last_bytes} + 4'd1
            : 4'd8;
    end
  end

  assign bc_new  = sat_add(bc_q, add_b);
  assign bc_pad  = sat_add(bc_q, 4'd8);
  assign lim     = bus.jumbo_enable ? JUMBO_W : MAX_W;
  assign act_max = bus.inband_fcs ? lim : lim - FCS_W;

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    good    = 1'b0;
    bad     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.tx_start && bus.tx_enable) begin
          state_d = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        state_d = ST_DATA;
        bc_d    = '0;
      end
      ST_DATA: begin
        bc_d = bc_new;
        // underrun and oversize outrank end-of-frame handling
        if (!bus.tx_data_valid || bc_new > act_max) begin
          state_d = ST_IFG;
          bad     = 1'b1;
        end else if (bus.tx_last && bus.inband_fcs) begin
          state_d = ST_IFG;
          good    = 1'b1;
        end else if (bus.tx_last && bc_new < MIN_W) begin
          state_d = ST_PAD;
        end else if (bus.tx_last) begin
          state_d = ST_FCS;
        end
      end
      ST_PAD: begin
        bc_d = bc_pad;
        if (!(bc_pad < MIN_W)) begin
          state_d = ST_FCS;
        end
      end
      ST_FCS: begin
        state_d = ST_IFG;
        good    = 1'b1;
      end
      ST_IFG: begin
        if (ifg_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge txclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
    end
  end

  assign ifg_load = (state_d == ST_IFG) && (state_q != ST_IFG);

  ifg_counter #(
    .IFG_CYCLES (IFG_CYCLES)
  ) u_ifg (
    .clk_i  (txclk),
    .rst_i  (reset),
    .load_i (ifg_load),
    .dec_i  (state_q == ST_IFG),
    .zero_o (ifg_zero)
  );

  // outputs are forced quiet while reset is asserted
  assign run = ~reset;

  assign bus.tx_ack         = run & (state_q == ST_PREAMBLE);
  assign bus.start_preamble = run & (state_q == ST_PREAMBLE);
  assign bus.crc_init       = run & (state_q == ST_PREAMBLE);
  assign bus.start_data     = run & (state_q == ST_DATA);
  assign bus.start_pad      = run & (state_q == ST_PAD);
  assign bus.start_fcs      = run & (state_q == ST_FCS);
  assign bus.crc_enable     = run & ~bus.inband_fcs
                            & ((state_q == ST_DATA)
                            | (state_q == ST_PAD));
  assign bus.transmitting   = run
                            & ((state_q == ST_PREAMBLE)
                            | (state_q == ST_DATA)
                            | (state_q == ST_PAD)
                            | (state_q == ST_FCS));
  assign bus.tx_end          = ~bus.transmitting;
  assign bus.tx_error        = run & bad;
  assign bus.bad_frame_sent  = run & bad;
  assign bus.good_frame_sent = run & good;
  assign bus.byte_count      = run ? bc_q : '0;

endmodule

// File: tb/tb_tx_state_machine.sv
// Directed and random frames against a per-frame schedule model
// built from frame length, pad and gap arithmetic.
module tb_tx_state_machine;

  localparam int IFG_CYCLES = 2;
  localparam int MIN_LEN    = 60;
  localparam int MAX_LEN    = 1518;
  localparam int JUMBO_LEN  = 9018;

  typedef struct {
    int st;
    int bc;
    int lb;
    bit start, en, valid, last;
    bit err, good, bad, rst;
  } cyc_t;

  logic txclk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   nbad  = 0;
  int   model_bc = 0;

  tx_state_machine_if bus();

  tx_state_machine #(
    .IFG_CYCLES (IFG_CYCLES),
    .MIN_LEN    (MIN_LEN),
    .MAX_LEN    (MAX_LEN),
    .JUMBO_LEN  (JUMBO_LEN)
  ) dut (
    .txclk (txclk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 txclk = ~txclk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      nbad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock cycle: drive, check mid-cycle, advance past the edge
  task automatic step(cyc_t c, bit inb, bit jum);
    logic [11:0] ef, gf;
    logic tr;
    reset             = c.rst;
    bus.tx_start      = c.start;
    bus.tx_enable     = c.en;
    bus.tx_data_valid = c.valid;
    bus.tx_last       = c.last;
    bus.tx_last_bytes = 3'(c.lb);
    bus.inband_fcs    = inb;
    bus.jumbo_enable  = jum;
    @(negedge txclk);
    tr = (c.st >= 1 && c.st <= 4);
    if (c.rst) ef = 12'b0000_0000_1000;
    else ef = {c.st == 1, c.st == 1, c.st == 2,
               c.st == 3, c.st == 4, c.st == 1,
               (c.st == 2 || c.st == 3) && !inb,
               tr, !tr, c.err, c.good, c.bad};
    gf = {bus.tx_ack, bus.start_preamble, bus.start_data,
          bus.start_pad, bus.start_fcs, bus.crc_init,
          bus.crc_enable, bus.transmitting, bus.tx_end,
          bus.tx_error, bus.good_frame_sent,
          bus.bad_frame_sent};
    chk($sformatf("flags st%0d", c.st), 32'(gf), 32'(ef));
    chk($sformatf("byte_count st%0d", c.st),
        32'(bus.byte_count), c.rst ? 0 : c.bc);
    @(posedge txclk);
    #1;
  endtask

  task automatic idle_cycles(int n, bit s, bit e);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = '{default: 0};
      c.start = s;
      c.en    = e;
      c.bc    = model_bc;
      step(c, 1'b0, 1'b0);
    end
  endtask

  task automatic run_frame(int nw, int lb, int ur, bit inb,
                           bit jum, bit hold, int ra);
    cyc_t c;
    int sum, mx, np, res;
    mx = (jum ? JUMBO_LEN : MAX_LEN) - (inb ? 0 : 4);
    c = '{default: 0};
    c.start = 1'b1;
    c.en    = 1'b1;
    c.bc    = model_bc;
    step(c, inb, jum);
    c.st    = 1;
    c.start = hold;
    c.en    = 1'($urandom_range(0, 1));
    step(c, inb, jum);
    sum = 0;
    res = 0;
    for (int i = 0; i < nw && res == 0; i++) begin
      c.st = 2; c.bc = sum; c.lb = lb;
      c.err = 0; c.good = 0; c.bad = 0;
      c.valid = (i != ur);
      c.last  = (i == nw - 1);
      c.rst   = (i == ra);
      c.en    = 1'($urandom_range(0, 1));
      if (c.rst) res = 4;
      else if (!c.valid) begin
        c.err = 1; c.bad = 1; res = 1;
      end else begin
        sum += c.last ? lb + 1 : 8;
        if (sum > 16383) sum = 16383;
        if (sum > mx) begin
          c.err = 1; c.bad = 1; res = 1;
        end else if (c.last && inb) begin
          c.good = 1; res = 1;
        end else if (c.last) res = 3;
      end
      step(c, inb, jum);
    end
    c = '{default: 0};
    c.start = hold;
    if (res == 4) begin
      model_bc = 0;
      c.start  = 1'b0;
      step(c, inb, jum);
      return;
    end
    if (res == 3) begin
      np = (sum < MIN_LEN) ? (MIN_LEN - sum + 7) / 8 : 0;
      for (int j = 0; j < np; j++) begin
        c.st = 3;
        c.bc = sum + 8 * j;
        step(c, inb, jum);
      end
      sum += 8 * np;
      c.st = 4; c.bc = sum; c.good = 1;
      step(c, inb, jum);
      c.good = 0;
    end
    for (int k = 0; k < IFG_CYCLES; k++) begin
      c.st = 5; c.bc = sum;
      c.en = 1'($urandom_range(0, 1));
      step(c, inb, jum);
    end
    model_bc = sum;
  endtask

  initial begin
    cyc_t c;
    int nw, ur, ra;
    c = '{default: 0};
    c.rst = 1; c.start = 1; c.en = 1;
    #1;
    step(c, 1'b0, 1'b0);
    step(c, 1'b0, 1'b0);
    model_bc = 0;
    idle_cycles(1, 1'b0, 1'b1);
    idle_cycles(3, 1'b1, 1'b0);
    run_frame(8, 3, -1, 0, 0, 0, -1);
    idle_cycles(1, 1'b0, 1'b1);
    run_frame(3, 3, -1, 0, 0, 0, -1);
    run_frame(8, 7, 3, 0, 0, 0, -1);
    run_frame(200, 7, -1, 0, 0, 0, -1);
    run_frame(200, 7, -1, 0, 1, 0, -1);
    run_frame(3, 3, -1, 1, 0, 0, -1);
    run_frame(8, 7, -1, 0, 0, 0, 3);
    run_frame(4, 0, -1, 0, 0, 1, -1);
    run_frame(9, 5, -1, 0, 0, 1, -1);
    idle_cycles(2, 1'b0, 1'b1);
    for (int f = 0; f < 40; f++) begin
      nw = $urandom_range(1, 12);
      ur = ($urandom_range(0, 7) == 0)
         ? $urandom_range(0, nw - 1) : -1;
      ra = ($urandom_range(0, 15) == 0)
         ? $urandom_range(0, nw - 1) : -1;
      run_frame(nw, $urandom_range(0, 7), ur,
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, ra);
      idle_cycles($urandom_range(0, 2), 1'b0, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule

// File: doc/tx_state_machine.md
TX_STATE_MACHINE -- requirements
Module: tx_state_machine

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 2: idle words inserted after each frame.
REQ-002 SHALL have parameter MIN_LEN, default 60: minimum bytes before FCS (DA through pad).
REQ-003 SHALL have parameter MAX_LEN, default 1518, and JUMBO_LEN, default 9018: maximum bytes, FCS included.
REQ-004 Ports; one clock, synchronous active-high reset:
- txclk, input, 1: sole clock; all state changes on rising edge.
- reset, input, 1: synchronous, active-high.
- tx_enable, input, 1: transmitter enabled.
- inband_fcs, input, 1: client supplies FCS; no pad, no FCS generation.
- jumbo_enable, input, 1: selects JUMBO_LEN instead of MAX_LEN.
- tx_start, input, 1: client has a frame ready.
- tx_data_valid, input, 1: client word valid.
- tx_last, input, 1: current word is the last of the frame.
- tx_last_bytes, input, 3: valid bytes in last word minus 1.
- tx_ack, output, 1: frame accepted; first data word is due the next cycle.
- start_preamble, start_data, start_pad, start_fcs, output, 1 each: state decodes.
- crc_init, output, 1: clear the CRC generator.
- crc_enable, output, 1: feed the current word to the CRC generator.
- transmitting, output, 1: in PREAMBLE, DATA, PAD or FCS.
- tx_end, output, 1: the inverse of transmitting.
- tx_error, output, 1: drive an XGMII error code this cycle.
- good_frame_sent, bad_frame_sent, output, 1 each: one-cycle status pulses.
- byte_count, output, 14: bytes sent in the current frame.

Function
REQ-005 States: IDLE=0, PREAMBLE=1, DATA=2, PAD=3, FCS=4, IFG=5. State register is 3 bits; codes 6 and 7 SHALL go to IDLE.
REQ-006 IDLE: tx_start & tx_enable -> PREAMBLE; otherwise stay in IDLE.
REQ-007 PREAMBLE lasts exactly 1 cycle, then DATA. tx_ack and crc_init are high only in PREAMBLE.
REQ-008 byte_count clears in PREAMBLE. In DATA it adds 8 per valid non-last word and tx_last_bytes+1 on the last word. In PAD it adds 8 per cycle. The register is 14 bits and saturates at 16383.
REQ-009 DATA, in priority order:
- (a) ~tx_data_valid (underrun), or the new byte_count exceeds the active maximum -> IFG with tx_error=1 and bad_frame_sent=1 in that cycle.
- (b) tx_last with inband_fcs -> IFG with good_frame_sent=1.
- (c) tx_last with new byte_count < MIN_LEN -> PAD.
- (d) tx_last otherwise -> FCS.
- Otherwise stay in DATA.
REQ-010 The "active maximum" in REQ-009 is MAX_LEN-4 when FCS is generated, or the full limit when inband_fcs=1. The limit is JUMBO_LEN when jumbo_enable=1.
REQ-011 PAD: stay while byte_count+8 < MIN_LEN; otherwise go to FCS on the next edge. The final pad word may overshoot MIN_LEN; the datapath truncates it.
REQ-012 FCS lasts exactly 1 cycle, then IFG; good_frame_sent=1 in that cycle.
REQ-013 IFG: load a down-counter with IFG_CYCLES-1 on entry and go to IDLE when it reaches 0. tx_start is ignored during IFG.
REQ-014 crc_enable = (DATA | PAD) & ~inband_fcs.
REQ-015 transmitting is high in states 1-4.
REQ-016 tx_enable deasserting mid-frame does not abort the frame; it only blocks the next IDLE->PREAMBLE transition.
REQ-017 good_frame_sent and bad_frame_sent are never high in the same cycle, and each is high for exactly one cycle per frame.

Reset
REQ-018 When reset=1 at an edge, all of the following SHALL hold after that edge: state=IDLE, byte_count=0, IFG counter=0. This applies even mid-frame; no status pulse is issued.
REQ-019 Output values during and after reset: transmitting=0, tx_end=1, and every other output 0.

Structure
REQ-020 State encodings, MIN_LEN, MAX_LEN, JUMBO_LEN and IFG_CYCLES defaults SHALL live in a shared package, tx_pkg, that the CRC and datapath blocks also use.
REQ-021 The IFG down-counter SHALL be a sub-module, ifg_counter.
REQ-022 The next-state logic SHALL be combinational, with a single registered state.

Verification
REQ-023 64-byte frame, inband_fcs=0: 7 full words, then last word with tx_last_bytes=3. Required: byte_count=60, one FCS cycle, good_frame_sent pulse, 2 IFG cycles, then IDLE.
REQ-024 20-byte frame: 2 full words, then last with tx_last_bytes=3. Required: PAD for 5 cycles, byte_count=60, then FCS and good_frame_sent.
REQ-025 Underrun: tx_data_valid=0 on the 4th DATA word. Required: tx_error=1 and bad_frame_sent=1 in that cycle, then IFG, with no FCS cycle.
REQ-026 Oversize: 1600-byte frame with jumbo_enable=0. Required: bad_frame_sent when byte_count first exceeds 1514. The same frame with jumbo_enable=1 completes with good_frame_sent.
REQ-027 Reset mid-DATA. Required: IDLE next cycle, byte_count=0, transmitting=0, no status pulse.
REQ-028 Back-to-back frames: tx_start held high continuously. Required: exactly IFG_CYCLES IFG cycles between FCS and the next PREAMBLE; tx_ack pulses once per frame.
